// File: rtl/leitor_display_dois.sv
`default_nettype none
// ============================================================================
// Module  : leitor_display_dois
// Brief   : Recovers the 0..99 value shown on a muxed two-digit 7-seg bus.
// Revision: 1.0 - initial release
// ============================================================================
module leitor_display_dois #(
    parameter int ESTAVEL = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:6]  segmentos,
    input  logic        sel,
    input  logic        amostra,
    output logic [31:0] valor,
    output logic        valido,
    output logic        erro
);

    localparam logic [3:0] C_ESTAVEL = 4'(ESTAVEL);
    localparam logic [0:6] C_BLANK   = 7'b1111111;

    logic       ult_sel_q, ult_sel_d;
    logic [0:6] ult_pat_q, ult_pat_d;
    logic [3:0] cont_q, cont_d;
    logic       conf_q, conf_d;
    logic       ok_u_q, ok_u_d, ok_d_q, ok_d_d;
    logic [3:0] reg_unidade_q, reg_unidade_d;
    logic [3:0] reg_dezena_q, reg_dezena_d;
    logic [6:0] valor_q, valor_d;
    logic       valido_q, valido_d;
    logic       erro_q, erro_d;
    logic [4:0] dec;
    logic [6:0] dez_ext;
    logic [6:0] dez10;

    // Returns {legal, digit}; active-low segment patterns.
    function automatic logic [4:0] decode(input logic [0:6] p);
        case (p)
            7'b0000001: decode = 5'b1_0000;
            7'b1001111: decode = 5'b1_0001;
            7'b0010010: decode = 5'b1_0010;
            7'b0000110: decode = 5'b1_0011;
            7'b1001100: decode = 5'b1_0100;
            7'b0100100: decode = 5'b1_0101;
            7'b0100000: decode = 5'b1_0110;
            7'b0001111: decode = 5'b1_0111;
            7'b0000000: decode = 5'b1_1000;
            7'b0000100: decode = 5'b1_1001;
            default:    decode = 5'b0_0000;
        endcase
    endfunction

    always_comb begin
        ult_sel_d = ult_sel_q;
        ult_pat_d = ult_pat_q;
        cont_d    = cont_q;
        conf_d    = 1'b0;
        if (amostra) begin
            if ((sel == ult_sel_q) && (segmentos == ult_pat_q)) begin
                // Saturation at ESTAVEL is what stops a held pattern reconfirming.
                if (cont_q != C_ESTAVEL) begin
                    cont_d = cont_q + 4'd1;
                    conf_d = (cont_q == C_ESTAVEL - 4'd1);
                end
            end else begin
                ult_sel_d = sel;
                ult_pat_d = segmentos;
                cont_d    = 4'd1;
                conf_d    = (C_ESTAVEL == 4'd1);
            end
        end
    end

    always_comb begin
        dec           = decode(ult_pat_q);
        ok_u_d        = ok_u_q;
        ok_d_d        = ok_d_q;
        reg_unidade_d = reg_unidade_q;
        reg_dezena_d  = reg_dezena_q;
        valor_d       = valor_q;
        valido_d      = 1'b0;
        erro_d        = 1'b0;
        if (conf_q) begin
            if (dec[4]) begin
                if (ult_sel_q) begin
                    reg_dezena_d = dec[3:0];
                    ok_d_d       = 1'b1;
                end else begin
                    reg_unidade_d = dec[3:0];
                    ok_u_d        = 1'b1;
                end
            end else begin
                erro_d = 1'b1;
                if (ult_sel_q) ok_d_d = 1'b0;
                else           ok_u_d = 1'b0;
            end
        end
        dez_ext = {3'b000, reg_dezena_d};
        dez10   = (dez_ext << 3) + (dez_ext << 1);
        if (ok_u_d && ok_d_d) begin
            valor_d  = dez10 + {3'b000, reg_unidade_d};
            valido_d = 1'b1;
            ok_u_d   = 1'b0;
            ok_d_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ult_sel_q     <= 1'b0;
            ult_pat_q     <= C_BLANK;
            cont_q        <= 4'd0;
            conf_q        <= 1'b0;
            ok_u_q        <= 1'b0;
            ok_d_q        <= 1'b0;
            reg_unidade_q <= 4'd0;
            reg_dezena_q  <= 4'd0;
            valor_q       <= 7'd0;
            valido_q      <= 1'b0;
            erro_q        <= 1'b0;
        end else begin
            ult_sel_q     <= ult_sel_d;
            ult_pat_q     <= ult_pat_d;
            cont_q        <= cont_d;
            conf_q        <= conf_d;
            ok_u_q        <= ok_u_d;
            ok_d_q        <= ok_d_d;
            reg_unidade_q <= reg_unidade_d;
            reg_dezena_q  <= reg_dezena_d;
            valor_q       <= valor_d;
            valido_q      <= valido_d;
            erro_q        <= erro_d;
        end
    end

    assign valor  = {25'd0, valor_q};
    assign valido = valido_q;
    assign erro   = erro_q;

endmodule
`default_nettype wire

// File: tb/tb_leitor_display_dois.sv
`default_nettype none
// ============================================================================
// Module  : tb_leitor_display_dois
// Brief   : Directed bench for leitor_display_dois (ESTAVEL=4 and ESTAVEL=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_leitor_display_dois;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [0:6]  seg_a = 7'b1111111;
    logic        sel_a = 1'b0;
    logic        am_a  = 1'b0;
    logic [0:6]  seg_b = 7'b1111111;
    logic        sel_b = 1'b0;
    logic        am_b  = 1'b0;
    logic [31:0] valor_a, valor_b;
    logic        valido_a, valido_b, erro_a, erro_b;

    int nchk = 0;
    int nerr = 0;
    int nv_a = 0, ne_a = 0, nv_b = 0, ne_b = 0, nboth = 0;

    always #5 clock = ~clock;

    leitor_display_dois #(.ESTAVEL(4)) dut_a (
        .clock(clock), .reset(reset), .segmentos(seg_a), .sel(sel_a),
        .amostra(am_a), .valor(valor_a), .valido(valido_a), .erro(erro_a)
    );

    leitor_display_dois #(.ESTAVEL(1)) dut_b (
        .clock(clock), .reset(reset), .segmentos(seg_b), .sel(sel_b),
        .amostra(am_b), .valor(valor_b), .valido(valido_b), .erro(erro_b)
    );

    always @(negedge clock) begin
        if (valido_a) nv_a++;
        if (erro_a)   ne_a++;
        if (valido_b) nv_b++;
        if (erro_b)   ne_b++;
        if ((valido_a && erro_a) || (valido_b && erro_b)) nboth++;
    end

    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                           P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                           P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000,
                           P9 = 7'b0000100, PB = 7'b1111111;

    typedef struct {
        logic [6:0] pat_u;
        logic [6:0] pat_d;
        int         exp_valor;
    } frame_t;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic stb_a(input logic s, input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            sel_a = s; seg_a = p; am_a = 1'b1;
        end
        @(negedge clock);
        am_a = 1'b0;
    endtask

    task automatic stb_gap_a(input logic s, input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            sel_a = s; seg_a = p; am_a = 1'b1;
            @(negedge clock);
            am_a = 1'b0;
            repeat (2) @(negedge clock);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    frame_t frames[6];
    int v0, e0;

    initial begin
        frames[0] = '{P5, P2, 25};
        frames[1] = '{P0, P0, 0};
        frames[2] = '{P9, P9, 99};
        frames[3] = '{P1, P7, 71};
        frames[4] = '{P8, P4, 48};
        frames[5] = '{P6, P3, 36};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_valor", valor_a, 0);
        chk("reset_valido", valido_a, 0);
        chk("reset_erro", erro_a, 0);
        chk("reset_valor_b", valor_b, 0);

        // Basic frame with exact latency
        stb_a(1'b0, P5, 4);
        v0 = nv_a;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            sel_a = 1'b1; seg_a = P2; am_a = 1'b1;
        end
        @(negedge clock);
        am_a = 1'b0;
        chk("basic_valido_k", valido_a, 0);
        @(negedge clock);
        chk("basic_valido_k1", valido_a, 1);
        chk("basic_valor", valor_a, 25);
        @(negedge clock);
        chk("basic_valido_after", valido_a, 0);
        chk("basic_one_pulse", nv_a - v0, 1);
        chk("basic_no_erro", ne_a, 0);

        // Hold and partial reconfirm
        v0 = nv_a; e0 = ne_a;
        stb_a(1'b1, P2, 10); idle(3);
        chk("hold_no_valido", nv_a - v0, 0);
        chk("hold_no_erro", ne_a - e0, 0);
        stb_a(1'b1, P1, 4); idle(3);
        chk("partial_no_valido", nv_a - v0, 0);
        stb_a(1'b0, P7, 4); idle(3);
        chk("reconf_valido", nv_a - v0, 1);
        chk("reconf_valor", valor_a, 17);

        // Glitch rejection
        v0 = nv_a;
        stb_a(1'b0, P5, 3);
        stb_a(1'b0, P6, 4);
        stb_a(1'b1, P9, 4); idle(3);
        chk("glitch_valido", nv_a - v0, 1);
        chk("glitch_valor", valor_a, 96);

        // Illegal code
        v0 = nv_a; e0 = ne_a;
        stb_a(1'b0, PB, 4); idle(3);
        chk("illegal_erro", ne_a - e0, 1);
        chk("illegal_no_valido", nv_a - v0, 0);
        chk("illegal_valor_hold", valor_a, 96);
        stb_a(1'b0, P3, 4);
        stb_a(1'b1, P0, 4); idle(3);
        chk("after_illegal_valido", nv_a - v0, 1);
        chk("after_illegal_valor", valor_a, 3);

        // Reset mid-frame, amostra high during reset
        stb_a(1'b0, P7, 4); idle(2);
        v0 = nv_a; e0 = ne_a;
        @(negedge clock);
        reset = 1'b1; sel_a = 1'b1; seg_a = P1; am_a = 1'b1;
        @(negedge clock);
        reset = 1'b0; am_a = 1'b0;
        chk("rst_valor_clear", valor_a, 0);
        stb_a(1'b1, P1, 4); idle(3);
        chk("rst_no_valido", nv_a - v0, 0);
        chk("rst_valor", valor_a, 0);
        stb_a(1'b0, P0, 4); idle(3);
        chk("rst_next_frame", valor_a, 10);
        chk("rst_no_erro", ne_a - e0, 0);

        // Strobe gaps
        v0 = nv_a;
        stb_gap_a(1'b0, P8, 3); idle(3);
        chk("gap_not_yet", nv_a - v0, 0);
        stb_gap_a(1'b0, P8, 1);
        stb_gap_a(1'b1, P4, 4); idle(3);
        chk("gap_valido", nv_a - v0, 1);
        chk("gap_valor", valor_a, 48);

        // ESTAVEL=1, alternating back-to-back strobes
        v0 = nv_b;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            sel_b = i[0]; seg_b = i[0] ? P4 : P8; am_b = 1'b1;
        end
        @(negedge clock);
        am_b = 1'b0;
        idle(3);
        chk("e1_valido_count", nv_b - v0, 3);
        chk("e1_valor", valor_b, 48);
        chk("e1_no_erro", ne_b, 0);

        // Table of frames
        foreach (frames[i]) begin
            v0 = nv_a; e0 = ne_a;
            stb_a(1'b0, frames[i].pat_u, 4);
            stb_a(1'b1, frames[i].pat_d, 4);
            idle(3);
            chk($sformatf("tbl%0d_valido", i), nv_a - v0, 1);
            chk($sformatf("tbl%0d_erro", i), ne_a - e0, 0);
            chk($sformatf("tbl%0d_valor", i), valor_a, frames[i].exp_valor);
        end

        chk("never_both", nboth, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/leitor_display_dois.md
# leitor_display_dois

Reads a time-multiplexed two-digit seven-segment bus and recovers the binary value being displayed. This is the inverse of the two-digit binary-to-7-segment display driver.

- Per-digit stability filter on each segment pattern.
- Decodes confirmed patterns back to BCD and checks their validity.
- Emits `dezena*10 + unidade` as a 32-bit value with a one-cycle `valido` pulse.
- Sits between a display-bus sampler (or the driver under loopback test) and the consumer logic.

## Interface

Parameters:

- `ESTAVEL`, default 4: consecutive identical samples needed to confirm a digit pattern. Legal range 1..15.

Ports:

- `clock`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `segmentos`  input  [0:6]  segment pattern, 0 = lit, 1 = off. Bit 0 = segment a … bit 6 = segment g.
- `sel`  input  1  digit on the bus: 0 = unidade, 1 = dezena.
- `amostra`  input  1  sample strobe; `segmentos` and `sel` are taken only in cycles where it is high.
- `valor`  output  [31:0]  last complete reading, zero-extended, range 0..99.
- `valido`  output  1  one-cycle pulse; `valor` was updated on this edge.
- `erro`  output  1  one-cycle pulse; a confirmed pattern was not a legal digit.

## Operation

Legal codes:

- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Any other pattern, including 1111111 (blank), is illegal.

Run tracker (registers `ult_sel`, `ult_pat`, `cont` [3:0]):

- On `amostra` with `sel==ult_sel` and `segmentos==ult_pat`: `cont` increments, saturating at ESTAVEL.
- On `amostra` with any difference: load `ult_sel`/`ult_pat`; `cont` = 1.
- Confirmation fires exactly once per run, on the sample that brings `cont` to ESTAVEL. With ESTAVEL=1, it fires on the first sample of every new run.
- Cycles without `amostra` leave the tracker unchanged. Gaps do not break a run.

On confirmation:

- Legal code: store the digit into `reg_unidade` or `reg_dezena` per `ult_sel`, and set `ok_u` or `ok_d`.
- Illegal code: clear the corresponding `ok_*` flag, keep the stored digit, and pulse `erro`.

Frame completion:

- When `ok_u && ok_d` are both set, load `valor = reg_dezena*10 + reg_unidade`, pulse `valido`, and clear both flags.
- A digit reconfirmed before the frame completes overwrites its stored digit.
- A re-held pattern never reconfirms, because `cont` is saturated.

Reset:

- Values: `valor`=0, `valido`=0, `erro`=0, `cont`=0, `ult_sel`=0, `ult_pat`=1111111, `ok_u`=`ok_d`=0, `reg_unidade`=`reg_dezena`=0.
- Reset has priority over `amostra`, which is ignored in a reset cycle.
- A partial frame is discarded.

Arithmetic: `dezena*10` is computed as `(d<<3)+(d<<1)` in 7 bits and zero-extended to 32.

## Timing

- Edge k samples the confirming `amostra`.
- Edge k+1 registers the confirmation and decode. `erro` is high during the cycle after edge k+1.
- If this confirmation completes the frame, edge k+1 also updates `valor` and raises `valido`. Both are high for the cycle after edge k+1.
- Latency is 2 cycles from the strobe cycle to the `valido`/`erro` cycle.
- `valido` and `erro` are never high in the same cycle. An illegal confirmation cannot complete a frame.
- `valor` holds between `valido` pulses.
- Back-to-back `amostra` every cycle is supported. There is no back-pressure.

## Test plan

- **Basic frame.** ESTAVEL=4, unidade 0100100 ×4, then dezena 0010010 ×4.
  - One `valido` pulse two cycles after the 8th strobe; `valor`=25; `erro` never high.
- **Glitch rejection.** Unidade 0100100 ×3, then 0100000 ×4, then dezena 0000100 ×4.
  - `valor`=96; exactly one `valido`.
- **Illegal code.** Unidade 1111111 ×4.
  - One `erro` pulse, no `valido`.
  - Then unidade 0000110 ×4 and dezena 0000001 ×4 give `valor`=3.
- **Hold and partial reconfirm.** After the basic frame, hold dezena 0010010 for 10 more strobes.
  - No pulses.
  - Then dezena 1001111 ×4 alone gives no `valido`.
  - Then unidade 0001111 ×4 gives `valor`=17.
- **Reset mid-frame.** Unidade 0001111 confirmed; `reset` high 1 cycle with `amostra` high; then dezena 1001111 ×4.
  - No `valido`; `valor`=0.
- **Strobe gaps and ESTAVEL=1.** With ESTAVEL=4, strobes separated by 3 idle cycles still confirm.
  - With ESTAVEL=1, alternating unidade 8 / dezena 4 strobes give a `valido` every second strobe with `valor`=48.
